mem_req_ctrl: RTL and testbench

Sequencing controller for the data-memory port of the MEM stage. It accepts one prepared load/store per instruction from the store/load formatting logic: address, write strobes, aligned write data and size. It drives that request onto the SRAM-like data bus using the req/addr_ok/data_ok handshake. It stalls the pipeline until the transaction completes and returns the raw read word. It also drains in-flight transactions that are cancelled by a pipeline flush.

---
 rtl/mem_req_ctrl_pkg.sv | 23 ++
 rtl/mem_req_ctrl_if.sv | 25 ++
 rtl/mem_req_ctrl.sv | 113 +++++++++++
 tb/tb_mem_req_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory request controller:
// FSM state encoding and the access-size codes used by the load/store formatter.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQ        = 3'd1,
    ST_WAIT       = 3'd2,
    ST_DONE       = 3'd3,
    ST_DRAIN_REQ  = 3'd4,
    ST_DRAIN_WAIT = 3'd5
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Drain states finish a cancelled transaction whose result is thrown away.
  function automatic logic is_drain(state_e s);
    return (s == ST_DRAIN_REQ) || (s == ST_DRAIN_WAIT);
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// SRAM-like data bus with req/addr_ok/data_ok handshake.
// master = the controller issuing requests, slave = the memory side.
interface mem_req_ctrl_if;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_req_ctrl.sv
// MEM-stage data-memory sequencer: issues one bus transaction per memory
// instruction, stalls the pipeline until it completes, and drains flushed ones.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic          mem_wr,
  input  logic [1:0]    mem_size,
  input  logic [31:0]   mem_addr,
  input  logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_wdata,
  input  logic          mem_ade,
  input  logic          flush,
  output logic          stall,
  output logic          mem_done,
  output logic [31:0]   mem_rdata,
  mem_req_ctrl_if.master bus
);

  state_e      r_state;
  logic        r_req;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        r_mem_done;
  logic [31:0] r_mem_rdata;

  logic        w_accept;

  assign w_accept = mem_valid & ~mem_ade & ~flush;

  // A new instruction arriving during a drain must wait for the bus to free up.
  assign stall = (w_accept && (r_state != ST_DONE)) ||
                 (mem_valid && is_drain(r_state));

  assign mem_done       = r_mem_done;
  assign mem_rdata      = r_mem_rdata;
  assign bus.data_req   = r_req;
  assign bus.data_wr    = r_wr;
  assign bus.data_size  = r_size;
  assign bus.data_addr  = r_addr;
  assign bus.data_wstrb = r_wstrb;
  assign bus.data_wdata = r_wdata;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= 32'd0;
      r_wstrb     <= 4'd0;
      r_wdata     <= 32'd0;
      r_mem_done  <= 1'b0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_mem_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wr    <= mem_wr;
            r_size  <= mem_size;
            r_addr  <= mem_addr;
            r_wstrb <= mem_wr ? mem_wstrb : 4'd0;
            r_wdata <= mem_wdata;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A raised request is never withdrawn; a flush only redirects to a drain.
          if (bus.data_addr_ok) begin
            r_req   <= 1'b0;
            r_state <= flush ? ST_DRAIN_WAIT : ST_WAIT;
          end else if (flush) begin
            r_state <= ST_DRAIN_REQ;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            r_state <= bus.data_data_ok ? ST_IDLE : ST_DRAIN_WAIT;
          end else if (bus.data_data_ok) begin
            r_mem_rdata <= bus.data_rdata;
            r_mem_done  <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        ST_DRAIN_REQ: begin
          if (bus.data_addr_ok) begin
            r_req   <= 1'b0;
            r_state <= ST_DRAIN_WAIT;
          end
        end
        ST_DRAIN_WAIT: begin
          if (bus.data_data_ok) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: inputs change just after the falling edge,
// outputs are compared 1 ns later, one test-plan scenario per block of steps.
module tb_mem_req_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ade;
  logic        flush;
  logic        stall;
  logic        mem_done;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_req_ctrl_if bus ();

  mem_req_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_wr    (mem_wr),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ade   (mem_ade),
    .flush     (flush),
    .stall     (stall),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata);
    mem_wr    = wr;
    mem_size  = size;
    mem_addr  = addr;
    mem_wstrb = wstrb;
    mem_wdata = wdata;
  endtask

  initial begin
    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_ade   = 1'b0;
    flush     = 1'b0;
    set_req(1'b0, SIZE_BYTE, 32'd0, 4'd0, 32'd0);
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'd0;

    // Reset state
    cyc(); cyc(); #1;
    check("rst_req",   32'(bus.data_req),  32'd0);
    check("rst_stall", 32'(stall),         32'd0);
    check("rst_done",  32'(mem_done),      32'd0);
    check("rst_rdata", mem_rdata,          32'd0);
    check("rst_addr",  bus.data_addr,      32'd0);

    // Best-case word load at 0x1004
    cyc(); rst = 1'b0; mem_valid = 1'b1;
    set_req(1'b0, SIZE_WORD, 32'h0000_1004, 4'hF, 32'h0);
    #1;
    check("t1_c0_stall", 32'(stall),        32'd1);
    check("t1_c0_req",   32'(bus.data_req), 32'd0);
    cyc(); bus.data_addr_ok = 1'b1; #1;
    check("t1_c1_req",   32'(bus.data_req),   32'd1);
    check("t1_c1_addr",  bus.data_addr,       32'h0000_1004);
    check("t1_c1_size",  32'(bus.data_size),  32'(SIZE_WORD));
    check("t1_c1_wr",    32'(bus.data_wr),    32'd0);
    check("t1_c1_wstrb", 32'(bus.data_wstrb), 32'd0);
    check("t1_c1_stall", 32'(stall),          32'd1);
    cyc(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    bus.data_rdata = 32'hDEAD_BEEF; #1;
    check("t1_c2_req",   32'(bus.data_req), 32'd0);
    check("t1_c2_stall", 32'(stall),        32'd1);
    check("t1_c2_done",  32'(mem_done),     32'd0);
    cyc(); bus.data_data_ok = 1'b0; #1;
    check("t1_c3_done",  32'(mem_done), 32'd1);
    check("t1_c3_stall", 32'(stall),    32'd0);
    check("t1_c3_rdata", mem_rdata,     32'hDEAD_BEEF);
    cyc(); mem_valid = 1'b0; #1;
    check("t1_c4_done",  32'(mem_done), 32'd0);

    // Byte store at 0x2003 with addr_ok two cycles late
    cyc(); mem_valid = 1'b1;
    set_req(1'b1, SIZE_BYTE, 32'h0000_2003, 4'b1000, 32'hAB00_0000); #1;
    check("t2_c0_stall", 32'(stall), 32'd1);
    cyc(); #1;
    check("t2_c1_req",   32'(bus.data_req),   32'd1);
    check("t2_c1_addr",  bus.data_addr,       32'h0000_2003);
    check("t2_c1_wstrb", 32'(bus.data_wstrb), 32'h8);
    check("t2_c1_wdata", bus.data_wdata,      32'hAB00_0000);
    check("t2_c1_wr",    32'(bus.data_wr),    32'd1);
    check("t2_c1_size",  32'(bus.data_size),  32'(SIZE_BYTE));
    cyc(); #1;
    check("t2_c2_req",   32'(bus.data_req), 32'd1);
    check("t2_c2_addr",  bus.data_addr,     32'h0000_2003);
    cyc(); bus.data_addr_ok = 1'b1; #1;
    check("t2_c3_req",   32'(bus.data_req),   32'd1);
    check("t2_c3_wstrb", 32'(bus.data_wstrb), 32'h8);
    check("t2_c3_wdata", bus.data_wdata,      32'hAB00_0000);
    cyc(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; #1;
    check("t2_c4_req",   32'(bus.data_req), 32'd0);
    check("t2_c4_stall", 32'(stall),        32'd1);
    cyc(); bus.data_data_ok = 1'b0; #1;
    check("t2_c5_done",  32'(mem_done), 32'd1);
    check("t2_c5_stall", 32'(stall),    32'd0);
    cyc(); mem_valid = 1'b0; #1;
    check("t2_c6_done",  32'(mem_done), 32'd0);

    // Load with address error: no bus access, no stall
    cyc(); mem_valid = 1'b1; mem_ade = 1'b1;
    set_req(1'b0, SIZE_WORD, 32'h0000_1002, 4'd0, 32'd0); #1;
    check("t3_c0_stall", 32'(stall), 32'd0);
    cyc(); #1;
    check("t3_c1_req",   32'(bus.data_req), 32'd0);
    check("t3_c1_stall", 32'(stall),        32'd0);
    cyc(); #1;
    check("t3_c2_req",   32'(bus.data_req), 32'd0);
    check("t3_c2_done",  32'(mem_done),     32'd0);
    cyc(); mem_valid = 1'b0; mem_ade = 1'b0;

    // Flush in the same cycle as data_ok, then a new load issues at once
    cyc(); mem_valid = 1'b1;
    set_req(1'b0, SIZE_WORD, 32'h0000_3000, 4'd0, 32'd0);
    cyc(); bus.data_addr_ok = 1'b1; #1;
    check("t4_c1_req",   32'(bus.data_req), 32'd1);
    cyc(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    bus.data_rdata = 32'h55AA_55AA; flush = 1'b1; #1;
    check("t4_c2_stall", 32'(stall), 32'd0);
    cyc(); flush = 1'b0; bus.data_data_ok = 1'b0;
    set_req(1'b0, SIZE_WORD, 32'h0000_3010, 4'd0, 32'd0); #1;
    check("t4_c3_done",  32'(mem_done),     32'd0);
    check("t4_c3_rdata", mem_rdata,         32'hDEAD_BEEF);
    check("t4_c3_req",   32'(bus.data_req), 32'd0);
    cyc(); bus.data_addr_ok = 1'b1; #1;
    check("t4_c4_req",   32'(bus.data_req), 32'd1);
    check("t4_c4_addr",  bus.data_addr,     32'h0000_3010);
    cyc(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    bus.data_rdata = 32'h0BAD_F00D;
    cyc(); bus.data_data_ok = 1'b0; #1;
    check("t4_c6_done",  32'(mem_done), 32'd1);
    check("t4_c6_rdata", mem_rdata,     32'h0BAD_F00D);
    cyc(); mem_valid = 1'b0;

    // Flush in REQ before addr_ok: drain, next load waits, then issues
    cyc(); mem_valid = 1'b1;
    set_req(1'b0, SIZE_WORD, 32'h0000_4000, 4'd0, 32'd0);
    cyc(); flush = 1'b1; #1;
    check("t5_c1_req",   32'(bus.data_req), 32'd1);
    check("t5_c1_stall", 32'(stall),        32'd0);
    cyc(); flush = 1'b0;
    set_req(1'b0, SIZE_WORD, 32'h0000_4040, 4'd0, 32'd0); #1;
    check("t5_c2_req",   32'(bus.data_req), 32'd1);
    check("t5_c2_addr",  bus.data_addr,     32'h0000_4000);
    check("t5_c2_stall", 32'(stall),        32'd1);
    cyc(); bus.data_addr_ok = 1'b1; #1;
    check("t5_c3_req",   32'(bus.data_req), 32'd1);
    check("t5_c3_stall", 32'(stall),        32'd1);
    cyc(); bus.data_addr_ok = 1'b0; #1;
    check("t5_c4_req",   32'(bus.data_req), 32'd0);
    check("t5_c4_stall", 32'(stall),        32'd1);
    check("t5_c4_done",  32'(mem_done),     32'd0);
    cyc(); bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF; #1;
    check("t5_c5_stall", 32'(stall), 32'd1);
    cyc(); bus.data_data_ok = 1'b0; #1;
    check("t5_c6_done",  32'(mem_done),     32'd0);
    check("t5_c6_stall", 32'(stall),        32'd1);
    check("t5_c6_rdata", mem_rdata,         32'h0BAD_F00D);
    check("t5_c6_req",   32'(bus.data_req), 32'd0);
    cyc(); bus.data_addr_ok = 1'b1; #1;
    check("t5_c7_req",   32'(bus.data_req), 32'd1);
    check("t5_c7_addr",  bus.data_addr,     32'h0000_4040);
    cyc(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    bus.data_rdata = 32'h600D_CAFE;
    cyc(); bus.data_data_ok = 1'b0; #1;
    check("t5_c9_done",  32'(mem_done), 32'd1);
    check("t5_c9_rdata", mem_rdata,     32'h600D_CAFE);
    cyc(); mem_valid = 1'b0;

    // Reset while in WAIT; a late data_ok must be ignored
    cyc(); mem_valid = 1'b1;
    set_req(1'b1, SIZE_WORD, 32'h0000_5000, 4'hF, 32'h1122_3344);
    cyc(); bus.data_addr_ok = 1'b1; #1;
    check("t6_c1_req",   32'(bus.data_req), 32'd1);
    check("t6_c1_wdata", bus.data_wdata,    32'h1122_3344);
    cyc(); bus.data_addr_ok = 1'b0; rst = 1'b1; #1;
    check("t6_c2_req",   32'(bus.data_req), 32'd0);
    cyc(); rst = 1'b0; mem_valid = 1'b0; bus.data_data_ok = 1'b1;
    bus.data_rdata = 32'h9999_9999; #1;
    check("t6_c3_req",   32'(bus.data_req),   32'd0);
    check("t6_c3_wr",    32'(bus.data_wr),    32'd0);
    check("t6_c3_size",  32'(bus.data_size),  32'd0);
    check("t6_c3_addr",  bus.data_addr,       32'd0);
    check("t6_c3_wstrb", 32'(bus.data_wstrb), 32'd0);
    check("t6_c3_wdata", bus.data_wdata,      32'd0);
    check("t6_c3_rdata", mem_rdata,           32'd0);
    check("t6_c3_done",  32'(mem_done),       32'd0);
    check("t6_c3_stall", 32'(stall),          32'd0);
    cyc(); bus.data_data_ok = 1'b0; #1;
    check("t6_c4_done",  32'(mem_done),     32'd0);
    check("t6_c4_rdata", mem_rdata,         32'd0);
    check("t6_c4_req",   32'(bus.data_req), 32'd0);
    check("t6_c4_stall", 32'(stall),        32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
